// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time,
// holds the returned word for decode, handles redirects and misaligned-target traps.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fault_o,
    output logic [31:0] fetch_cnt_o
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   w_inst_nxt;
    logic              r_kill;
    logic              w_kill_nxt;
    logic              r_fault_pend;
    logic              w_fault_pend_nxt;
    logic [XLEN-1:0]   r_cnt;
    logic [XLEN-1:0]   w_cnt_nxt;
    logic              w_redir_ok;
    logic              w_redir_bad;

    assign w_redir_ok  = redirect_valid_i & (redirect_pc_i[1:0] == 2'b00);
    assign w_redir_bad = redirect_valid_i & (redirect_pc_i[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= NOP;
            r_kill       <= 1'b0;
            r_fault_pend <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_kill       <= w_kill_nxt;
            r_fault_pend <= w_fault_pend_nxt;
            r_cnt        <= w_cnt_nxt;
        end
    end

    // Next-state, PC and bookkeeping
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_kill_nxt       = r_kill;
        w_fault_pend_nxt = r_fault_pend;
        w_cnt_nxt        = r_cnt;

        unique case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
                if (redirect_valid_i) begin
                    w_pc_nxt = redirect_pc_i;
                end
                if (w_redir_bad) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_REQ: begin
                w_state_nxt = S_WAIT;
                if (redirect_valid_i) begin
                    w_pc_nxt   = redirect_pc_i;
                    w_kill_nxt = 1'b1;
                end
                if (w_redir_bad) begin
                    w_fault_pend_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (redirect_valid_i) begin
                    w_pc_nxt = redirect_pc_i;
                end
                if (!imem_rvalid_i) begin
                    if (redirect_valid_i) begin
                        w_kill_nxt = 1'b1;
                    end
                    if (w_redir_bad) begin
                        w_fault_pend_nxt = 1'b1;
                    end
                end else begin
                    // Every response retires the pending kill/fault markers
                    w_kill_nxt       = 1'b0;
                    w_fault_pend_nxt = 1'b0;
                    if (r_fault_pend || w_redir_bad) begin
                        w_state_nxt = S_FAULT;
                    end else if (r_kill || w_redir_ok) begin
                        w_state_nxt = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_inst_nxt  = imem_rdata_i;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready_i) begin
                    w_cnt_nxt = r_cnt + XLEN'(1);
                end
                if (w_redir_ok) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = redirect_pc_i;
                end else if (w_redir_bad) begin
                    w_state_nxt = S_FAULT;
                    w_pc_nxt    = redirect_pc_i;
                end else if (inst_ready_i) begin
                    w_state_nxt = S_REQ;
                    w_pc_nxt    = r_pc + PC_STEP;
                end
            end
            S_FAULT: begin
                if (redirect_valid_i) begin
                    w_pc_nxt = redirect_pc_i;
                end
                if (w_redir_ok) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    assign imem_req_o   = (r_state == S_REQ);
    assign imem_addr_o  = (r_state == S_REQ) ? r_pc : '0;
    assign inst_valid_o = (r_state == S_HOLD);
    assign inst_o       = (r_state == S_HOLD) ? r_inst : NOP;
    assign pc_o         = r_pc;
    assign fault_o      = (r_state == S_FAULT);
    assign fetch_cnt_o  = r_cnt;

endmodule
